// File: rtl/mem_arb_pkg.sv
// Shared types and reset values for the instruction/data memory arbiter.
// The MEM_ARB_PERF_EN build adds the performance counter bank.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFETCH = 2'd1,
      DACC   = 2'd2
   } arb_state_t;

   // One increment strobe per counter.
   typedef struct packed {
      logic icyc;
      logic dcyc;
      logic conf;
   } perf_cnt_t;

   localparam arb_state_t RST_STATE = IDLE;
   localparam logic       RST_VALID = 1'b0;
   localparam logic       RST_WE    = 1'b0;

endpackage

// File: rtl/mem_arb_perf.sv
// Stall and conflict counter bank for mem_arbiter.
// Present only when MEM_ARB_PERF_EN is defined.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf
   import mem_arb_pkg::*;
#(
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  perf_cnt_t         inc,
   output logic [PERF_W-1:0] icyc,
   output logic [PERF_W-1:0] dcyc,
   output logic [PERF_W-1:0] conf
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         icyc <= '0;
         dcyc <= '0;
         conf <= '0;
      end else begin
         if (inc.icyc) icyc <= icyc + 1'b1;
         if (inc.dcyc) dcyc <= dcyc + 1'b1;
         if (inc.conf) conf <= conf + 1'b1;
      end
   end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data ports.
// Define MEM_ARB_PERF_EN to add the perf_* counter outputs.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef MEM_ARB_PERF_EN
   ,
   parameter int PERF_W = 32
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_imem,
   output logic [DATA_W-1:0] imem_instn,
   output logic              Iwait,
   input  logic              memaccessM,
   input  logic              dmem_we,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_wd,
   output logic [DATA_W-1:0] dmem_rd,
   output logic              Dwait,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_icyc,
   output logic [PERF_W-1:0] perf_dcyc,
   output logic [PERF_W-1:0] perf_conf
`endif
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic              ld_d;
   logic              ld_i;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              ibuf_valid;
   logic [ADDR_W-1:0] ibuf_tag;
   logic [DATA_W-1:0] ibuf_data;
   logic              dvalid;
   logic [DATA_W-1:0] ddata;

   logic ipend;
   logic dpend;
   logic advance;
   logic i_done;
   logic d_done;

   assign Iwait      = !(ibuf_valid && ibuf_tag == pc_imem);
   assign Dwait      = memaccessM && !dvalid;
   assign imem_instn = ibuf_data;
   assign dmem_rd    = ddata;

   assign ipend   = Iwait;
   assign dpend   = Dwait;
   assign advance = !Iwait && !Dwait;

   // Request is decoded from state so reset withdraws it at once.
   assign mem_req   = (state_q != IDLE);
   assign mem_we    = (state_q == DACC) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign i_done = (state_q == IFETCH) && mem_ready;
   assign d_done = (state_q == DACC) && mem_ready;

   // Data wins: the M-stage instruction is older than the fetch.
   always_comb begin
      state_d = state_q;
      ld_d    = 1'b0;
      ld_i    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dpend) begin
               state_d = DACC;
               ld_d    = 1'b1;
            end else if (ipend) begin
               state_d = IFETCH;
               ld_i    = 1'b1;
            end
         end
         IFETCH, DACC: begin
            if (mem_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RST_STATE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= RST_WE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (ld_d) begin
         we_q    <= dmem_we;
         addr_q  <= dmem_addr;
         wdata_q <= dmem_wd;
      end else if (ld_i) begin
         we_q    <= 1'b0;
         addr_q  <= pc_imem;
      end
   end

   // A fetch result is kept even after a redirect; the tag sorts it out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ibuf_valid <= RST_VALID;
         ibuf_tag   <= '0;
         ibuf_data  <= '0;
      end else if (i_done) begin
         ibuf_valid <= 1'b1;
         ibuf_tag   <= addr_q;
         ibuf_data  <= mem_rdata;
      end else if (d_done && we_q && addr_q == ibuf_tag) begin
         ibuf_valid <= 1'b0;
      end
   end

   // dvalid covers one M-stage access until the pipeline advances.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dvalid <= RST_VALID;
         ddata  <= '0;
      end else if (d_done && memaccessM) begin
         dvalid <= 1'b1;
         if (!we_q) ddata <= mem_rdata;
      end else if (dvalid && advance) begin
         dvalid <= 1'b0;
      end
   end

`ifdef MEM_ARB_PERF_EN
   perf_cnt_t inc;

   assign inc.icyc = Iwait;
   assign inc.dcyc = Dwait;
   assign inc.conf = (state_q == IDLE) && ipend && dpend;

   mem_arb_perf #(
      .PERF_W (PERF_W)
   ) u_perf (
      .clk   (clk),
      .reset (reset),
      .inc   (inc),
      .icyc  (perf_icyc),
      .dcyc  (perf_dcyc),
      .conf  (perf_conf)
   );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner
// sequences and a randomized core model against a word memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_imem;
   logic [31:0] imem_instn;
   logic        Iwait;
   logic        memaccessM;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wd;
   logic [31:0] dmem_rd;
   logic        Dwait;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_icyc;
   logic [31:0] perf_dcyc;
   logic [31:0] perf_conf;
   int          n_icyc;
   int          n_dcyc;
   int          n_conf;
`endif

   logic [31:0] mem [256];
   int          n_vec;
   int          n_err;
   int          wr_cnt;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:2]];

   mem_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .pc_imem    (pc_imem),
      .imem_instn (imem_instn),
      .Iwait      (Iwait),
      .memaccessM (memaccessM),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wd    (dmem_wd),
      .dmem_rd    (dmem_rd),
      .Dwait      (Dwait),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_icyc  (perf_icyc),
      .perf_dcyc  (perf_dcyc),
      .perf_conf  (perf_conf)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic        ma;
      logic [31:0] da;
      logic        e_iw;
      logic        e_dw;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_instn;
      logic [31:0] e_drd;
   } vec_t;

   vec_t tv [16];

   function automatic vec_t mkv(
      input logic [31:0] pc, input logic ma, input logic [31:0] da,
      input logic iw, input logic dw, input logic rq,
      input logic [31:0] ea, input logic [31:0] ei,
      input logic [31:0] ed);
      vec_t v;
      v.pc = pc; v.ma = ma; v.da = da;
      v.e_iw = iw; v.e_dw = dw; v.e_req = rq;
      v.e_addr = ea; v.e_instn = ei; v.e_drd = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic [31:0] pc, input logic ma,
                      input logic we, input logic [31:0] da,
                      input logic [31:0] wd, input logic rdy);
      pc_imem    = pc;
      memaccessM = ma;
      dmem_we    = we;
      dmem_addr  = da;
      dmem_wd    = wd;
      mem_ready  = rdy;
   endtask

   // Advance one cycle; the memory commits a write just after the edge.
   task automatic tick();
      logic        w;
      logic [7:0]  a;
      logic [31:0] d;
      w = mem_req && mem_ready && mem_we;
      a = mem_addr[9:2];
      d = mem_wdata;
`ifdef MEM_ARB_PERF_EN
      if (!reset) begin
         if (Iwait) n_icyc++;
         if (Dwait) n_dcyc++;
         if (!mem_req && Iwait && Dwait) n_conf++;
      end
`endif
      @(posedge clk);
      #1;
      if (w) begin
         mem[a] = d;
         wr_cnt++;
      end
      @(negedge clk);
   endtask

   logic [31:0] pc, da, wd, pa, pw;
   logic        ma, we, prq, pwe, adv;
   int          stall, base;

   initial begin
      n_vec = 0; n_err = 0; wr_cnt = 0;
`ifdef MEM_ARB_PERF_EN
      n_icyc = 0; n_dcyc = 0; n_conf = 0;
`endif
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[0]    = 32'h0050_0093;
      mem[1]    = 32'h1111_1111;
      mem[2]    = 32'h2222_2222;
      mem[4]    = 32'h4444_4444;
      mem[8'h10] = 32'h4040_4040;
      mem[8'h40] = 32'hDEAD_BEEF;

      tv[0]  = mkv(32'h00, 0, 0, 1, 0, 0, 0, 0, 0);
      tv[1]  = mkv(32'h00, 0, 0, 1, 0, 1, 32'h00, 0, 0);
      tv[2]  = mkv(32'h00, 0, 0, 0, 0, 0, 0, 32'h0050_0093, 0);
      tv[3]  = mkv(32'h04, 0, 0, 1, 0, 0, 0, 0, 0);
      tv[4]  = mkv(32'h04, 0, 0, 1, 0, 1, 32'h04, 0, 0);
      tv[5]  = mkv(32'h04, 0, 0, 0, 0, 0, 0, 32'h1111_1111, 0);
      tv[6]  = mkv(32'h04, 0, 0, 0, 0, 0, 0, 32'h1111_1111, 0);
      tv[7]  = mkv(32'h08, 0, 0, 1, 0, 0, 0, 0, 0);
      tv[8]  = mkv(32'h08, 0, 0, 1, 0, 1, 32'h08, 0, 0);
      tv[9]  = mkv(32'h08, 0, 0, 0, 0, 0, 0, 32'h2222_2222, 0);
      tv[10] = mkv(32'h10, 1, 32'h100, 1, 1, 0, 0, 0, 0);
      tv[11] = mkv(32'h10, 1, 32'h100, 1, 1, 1, 32'h100, 0, 0);
      tv[12] = mkv(32'h10, 1, 32'h100, 1, 0, 0, 0, 0,
                   32'hDEAD_BEEF);
      tv[13] = mkv(32'h10, 1, 32'h100, 1, 0, 1, 32'h10, 0,
                   32'hDEAD_BEEF);
      tv[14] = mkv(32'h10, 1, 32'h100, 0, 0, 0, 0, 32'h4444_4444,
                   32'hDEAD_BEEF);
      tv[15] = mkv(32'h10, 0, 0, 0, 0, 0, 0, 32'h4444_4444, 0);

      // Reset state
      reset = 1'b1;
      drv(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      #1;
      chk("rst mem_req", mem_req, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst Iwait", Iwait, 1);
      chk("rst Dwait", Dwait, 0);
      chk("rst instn", imem_instn, 0);
      memaccessM = 1'b1;
      #1;
      chk("rst Dwait follows macc", Dwait, 1);
      memaccessM = 1'b0;
      reset = 1'b0;

      // Cold fetch, hit/miss, load-vs-fetch conflict
      for (int i = 0; i < 16; i++) begin
         drv(tv[i].pc, tv[i].ma, 0, tv[i].da, 0, 1);
         #1;
         chk($sformatf("v%0d Iwait", i), Iwait, tv[i].e_iw);
         chk($sformatf("v%0d Dwait", i), Dwait, tv[i].e_dw);
         chk($sformatf("v%0d mem_req", i), mem_req, tv[i].e_req);
         if (tv[i].e_req) begin
            chk($sformatf("v%0d mem_addr", i), mem_addr,
                tv[i].e_addr);
            chk($sformatf("v%0d mem_we", i), mem_we, 0);
         end
         if (!tv[i].e_iw)
            chk($sformatf("v%0d instn", i), imem_instn,
                tv[i].e_instn);
         if (tv[i].ma && !tv[i].e_dw)
            chk($sformatf("v%0d dmem_rd", i), dmem_rd, tv[i].e_drd);
         tick();
      end

      // Slow store held across five not-ready cycles
      drv(32'h10, 1, 1, 32'h200, 32'hCAFE_F00D, 0);
      #1;
      chk("st Dwait idle", Dwait, 1);
      chk("st req idle", mem_req, 0);
      base = wr_cnt;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("st hold req", mem_req, 1);
         chk("st hold addr", mem_addr, 32'h200);
         chk("st hold wdata", mem_wdata, 32'hCAFE_F00D);
         chk("st hold we", mem_we, 1);
         chk("st hold Dwait", Dwait, 1);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      chk("st last req", mem_req, 1);
      tick();
      #1;
      chk("st done Dwait", Dwait, 0);
      chk("st write count", wr_cnt - base, 1);
      chk("st mem word", mem[8'h80], 32'hCAFE_F00D);
      tick();
      memaccessM = 1'b0;
      #1;
      chk("st after Dwait", Dwait, 0);
      chk("st after req", mem_req, 0);
      tick();
      #1;
      chk("st no reissue req", mem_req, 0);
      chk("st no reissue count", wr_cnt - base, 1);

      // Load abandoned by the core, then re-requested
      drv(32'h10, 1, 0, 32'h100, 0, 0);
      tick();
      #1;
      chk("drop req", mem_req, 1);
      memaccessM = 1'b0;
      mem_ready  = 1'b1;
      #1;
      chk("drop Dwait", Dwait, 0);
      tick();
      memaccessM = 1'b1;
      #1;
      chk("drop discarded Dwait", Dwait, 1);
      chk("drop discarded req", mem_req, 0);
      tick();
      tick();
      #1;
      chk("drop reload Dwait", Dwait, 0);
      chk("drop reload data", dmem_rd, 32'hDEAD_BEEF);
      tick();
      memaccessM = 1'b0;

      // Redirect while a fetch is outstanding
      drv(32'h20, 0, 0, 0, 0, 0);
      #1;
      chk("rd Iwait", Iwait, 1);
      chk("rd idle req", mem_req, 0);
      tick();
      #1;
      chk("rd req", mem_req, 1);
      chk("rd addr", mem_addr, 32'h20);
      pc_imem   = 32'h40;
      mem_ready = 1'b1;
      #1;
      chk("rd held addr", mem_addr, 32'h20);
      chk("rd Iwait", Iwait, 1);
      tick();
      #1;
      chk("rd stale Iwait", Iwait, 1);
      chk("rd turnaround req", mem_req, 0);
      tick();
      #1;
      chk("rd refetch req", mem_req, 1);
      chk("rd refetch addr", mem_addr, 32'h40);
      tick();
      #1;
      chk("rd hit Iwait", Iwait, 0);
      chk("rd hit instn", imem_instn, 32'h4040_4040);

      // Store over the buffered instruction forces a refetch
      drv(32'h40, 1, 1, 32'h40, 32'h1357_9BDF, 1);
      #1;
      chk("smc Iwait", Iwait, 0);
      chk("smc Dwait", Dwait, 1);
      tick();
      #1;
      chk("smc st addr", mem_addr, 32'h40);
      chk("smc st we", mem_we, 1);
      tick();
      #1;
      chk("smc inval Iwait", Iwait, 1);
      chk("smc Dwait", Dwait, 0);
      tick();
      #1;
      chk("smc refetch req", mem_req, 1);
      chk("smc refetch addr", mem_addr, 32'h40);
      chk("smc refetch we", mem_we, 0);
      tick();
      #1;
      chk("smc new Iwait", Iwait, 0);
      chk("smc new instn", imem_instn, 32'h1357_9BDF);
      tick();
      memaccessM = 1'b0;

      // Asynchronous reset in the middle of a store
      drv(32'h40, 1, 1, 32'h200, 32'h0BAD_F00D, 0);
      tick();
      #1;
      chk("ar req before", mem_req, 1);
      base = wr_cnt;
      #2;
      reset = 1'b1;
      #1;
      chk("ar req", mem_req, 0);
      chk("ar mem_addr", mem_addr, 0);
      chk("ar Iwait", Iwait, 1);
      chk("ar Dwait", Dwait, 1);
      chk("ar dmem_rd", dmem_rd, 0);
`ifdef MEM_ARB_PERF_EN
      chk("ar perf_icyc", perf_icyc, 0);
      chk("ar perf_dcyc", perf_dcyc, 0);
      chk("ar perf_conf", perf_conf, 0);
      n_icyc = 0; n_dcyc = 0; n_conf = 0;
`endif
      tick();
      reset = 1'b0;
      memaccessM = 1'b0;
      #1;
      chk("ar idle req", mem_req, 0);
      chk("ar no write", wr_cnt - base, 0);
      chk("ar mem kept", mem[8'h80], 32'hCAFE_F00D);

      // Randomized core against the memory contents
      pc = 0; ma = 0; we = 0; da = 0; wd = 0;
      prq = 0; pa = 0; pw = 0; pwe = 0;
      stall = 0; base = wr_cnt;
      for (int c = 0; c < 2000; c++) begin
         drv(pc, ma, we, da, wd, $urandom_range(0, 3) != 0);
         #1;
         if (!Iwait)
            chk("rnd instn", imem_instn, mem[pc[9:2]]);
         if (ma && !Dwait && !we)
            chk("rnd load", dmem_rd, mem[da[9:2]]);
         if (prq) begin
            chk("rnd hold req", mem_req, 1);
            chk("rnd hold addr", mem_addr, pa);
            chk("rnd hold we", mem_we, pwe);
            chk("rnd hold wdata", mem_wdata, pw);
         end
         if (mem_req && mem_we) begin
            chk("rnd st addr", mem_addr, da);
            chk("rnd st wdata", mem_wdata, wd);
         end
         prq = mem_req && !mem_ready;
         pa  = mem_addr;
         pwe = mem_we;
         pw  = mem_wdata;
         adv = !Iwait && !Dwait;
         if (adv && ma && we)
            chk("rnd store once", wr_cnt - base, 1);
         stall = adv ? 0 : stall + 1;
         if (stall > 40) begin
            chk("rnd progress stall", stall, 0);
            break;
         end
         tick();
         if (adv) begin
            pc = ($urandom_range(0, 1) != 0) ? pc + 4 :
                 32'($urandom_range(0, 15)) << 2;
            pc = pc & 32'h3C;
            ma = ($urandom_range(0, 1) != 0);
            we = ($urandom_range(0, 2) == 0);
            da = 32'($urandom_range(0, 15)) << 2;
            wd = $urandom;
            base = wr_cnt;
         end else if ($urandom_range(0, 9) == 0) begin
            pc = 32'($urandom_range(0, 15)) << 2;
         end
      end

`ifdef MEM_ARB_PERF_EN
      #1;
      chk("perf_icyc", perf_icyc, n_icyc);
      chk("perf_dcyc", perf_dcyc, n_dcyc);
      chk("perf_conf", perf_conf, n_conf);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
